// File: rtl/tsg_ctrl_pkg.sv
// Shared definitions for the Chase test-syndrome-generator sequencer.
package tsg_ctrl_pkg;

  localparam int TP_NUM_MAX = 8;

  typedef enum logic [2:0] {
    S_RST     = 3'd0,
    S_IDLE    = 3'd1,
    S_INIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_FLUSH   = 3'd4
  } state_e;

endpackage

// File: rtl/tp_idx_cnt.sv
// Test-pattern index counter: clearable up-counter with a terminal flag.
module tp_idx_cnt #(
  parameter int TP_NUM = 4,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             in_ArstN,
  input  logic             in_clr,
  input  logic             in_inc,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TP_NUM - 1);

  logic [IDX_W-1:0] idx_d, idx_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    if (in_clr) begin
      idx_d = '0;
    end else if (in_inc && !out_last) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge in_ArstN) begin
    if (!in_ArstN) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign out_idx  = idx_q;
  assign out_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/tsg_chase_sched.sv
// Sequencer that loads the test syndrome generator and walks it through
// TP_NUM patterns, presenting each one downstream with valid/ready.
module tsg_chase_sched
  import tsg_ctrl_pkg::*;
#(
  parameter int GF_LEN = 10,
  parameter int TP_NUM = 4,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             in_ctr_ArstN,
  input  logic             in_ctr_en,
  input  logic             in_ctr_start,
  input  logic             in_ctr_abort,
  input  logic             in_ready,
  output logic             out_ctr_Srst,
  output logic             out_ctr_en,
  output logic             out_ctr_calInit,
  output logic             out_ctr_enCal,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_tp_idx,
  output logic             out_last,
  output logic             out_busy,
  output logic             out_done
);

  if (GF_LEN < 1 || TP_NUM < 2 || TP_NUM > TP_NUM_MAX || (1 << IDX_W) < TP_NUM) begin : g_bad_param
    $error("tsg_chase_sched: illegal GF_LEN/TP_NUM/IDX_W combination");
  end

  state_e state_d, state_q;
  logic   done_d, done_q;
  logic   cnt_clr, cnt_inc, cnt_last;
  logic   last_xfer;

  tp_idx_cnt #(
    .TP_NUM (TP_NUM),
    .IDX_W  (IDX_W)
  ) u_idx (
    .clk      (clk),
    .in_ArstN (in_ctr_ArstN),
    .in_clr   (cnt_clr),
    .in_inc   (cnt_inc),
    .out_idx  (out_tp_idx),
    .out_last (cnt_last)
  );

  always_comb begin
    state_d         = state_q;
    done_d          = done_q;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    last_xfer       = 1'b0;
    out_ctr_calInit = 1'b0;
    out_ctr_enCal   = 1'b0;
    out_valid       = 1'b0;
    case (state_q)
      S_RST:   state_d = S_IDLE;
      S_IDLE: begin
        if (in_ctr_en && in_ctr_start && !in_ctr_abort) begin
          state_d = S_INIT;
          cnt_clr = 1'b1;
        end
      end
      S_INIT: begin
        if (in_ctr_abort) begin
          state_d = S_FLUSH;
        end else if (in_ctr_en) begin
          out_ctr_calInit = 1'b1;
          state_d         = S_PRESENT;
        end
      end
      S_PRESENT: begin
        out_valid = in_ctr_en;
        // Abort wins over a same-cycle transfer: no step, no done.
        if (in_ctr_abort) begin
          state_d = S_FLUSH;
        end else if (in_ctr_en && in_ready) begin
          if (cnt_last) begin
            state_d   = S_IDLE;
            last_xfer = 1'b1;
          end else begin
            out_ctr_enCal = 1'b1;
            cnt_inc       = 1'b1;
          end
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_RST;
    endcase
    // The done register freezes while disabled, stretching the pulse.
    if (in_ctr_en) begin
      done_d = last_xfer;
    end
  end

  // NOTE: only control state is reset here; the async reset puts the FSM in S_RST.
  always_ff @(posedge clk or negedge in_ctr_ArstN) begin
    if (!in_ctr_ArstN) begin
      state_q <= S_RST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign out_ctr_Srst = (state_q == S_RST) || (state_q == S_FLUSH);
  assign out_ctr_en   = in_ctr_en | out_ctr_Srst;
  assign out_last     = cnt_last && (state_q == S_PRESENT);
  assign out_busy     = (state_q == S_INIT) || (state_q == S_PRESENT) || (state_q == S_FLUSH);
  assign out_done     = done_q;

endmodule

// File: doc/tsg_chase_sched.md
# tsg_chase_sched

Sequencer for the test syndrome generator in the Chase-style BCH soft decoder. After the hard-decision syndromes are valid, it:
- loads them into the generator,
- steps the generator through `TP_NUM` test patterns,
- presents each resulting test syndrome set downstream with a valid/ready handshake.

It sits between the hard-decision syndrome calculator and the key-equation solver. It owns every control input of the generator.

## Interface
Parameters:
- `GF_LEN`, 10, field width; used only for display/consistency checks.
- `TP_NUM`, 4, number of test patterns per codeword; legal range 2..8.
- `IDX_W`, 3, width of the pattern index; must satisfy 2^`IDX_W` >= `TP_NUM`.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `in_ctr_ArstN`  in  1  reset, asynchronous assert, active-low.
- `in_ctr_en`  in  1  global enable; low = stall.
- `in_ctr_start`  in  1  pulse: hard-decision syndromes valid for one codeword.
- `in_ctr_abort`  in  1  pulse: discard the current codeword.
- `in_ready`  in  1  downstream accepts the current test syndrome.
- `out_ctr_Srst`  out  1  synchronous reset to the generator.
- `out_ctr_en`  out  1  generator enable.
- `out_ctr_calInit`  out  1  generator: load hard-decision syndromes and reset its gray counter.
- `out_ctr_enCal`  out  1  generator: apply next pattern step.
- `out_valid`  out  1  generator outputs hold a valid test syndrome set.
- `out_tp_idx`  out  `IDX_W`  binary index of the presented pattern, 0..`TP_NUM`-1.
- `out_last`  out  1  presented pattern is index `TP_NUM`-1.
- `out_busy`  out  1  codeword in progress; start is ignored.
- `out_done`  out  1  one-cycle pulse after the last pattern is accepted.

## Operation
States: `RST`, `IDLE`, `INIT`, `PRESENT`, `FLUSH`.
- **`RST`** (entered on async reset): `out_ctr_Srst`=1; go to `IDLE` on the first edge with reset released.
- **`IDLE`**: if `in_ctr_en` & `in_ctr_start` & !`in_ctr_abort`, go to `INIT` and clear the index to 0.
- **`INIT`**: `out_ctr_calInit`=1 for exactly one enabled cycle, then go to `PRESENT`.
- **`PRESENT`**:
  - `out_valid` = `in_ctr_en`.
  - A transfer is `out_valid` & `in_ready`.
  - On a transfer with !`out_last`: `out_ctr_enCal`=1 combinationally in the same cycle, and the index increments.
  - On a transfer with `out_last`: go to `IDLE` and set the `out_done` register.
  - `out_ctr_enCal` is never asserted on the last transfer.
- **`FLUSH`**: `out_ctr_Srst`=1 for one cycle, then go to `IDLE`.
- **Abort**: `in_ctr_abort` in `INIT` or `PRESENT` (regardless of `in_ctr_en`) goes to `FLUSH`. Abort has priority over a same-cycle transfer or start. Abort in `IDLE` is ignored.

Output rules:
- `out_ctr_en` = `in_ctr_en` | `out_ctr_Srst`.
- `out_ctr_calInit` and `out_ctr_enCal` are forced 0 when `in_ctr_en`=0.
- `out_busy` = state is `INIT`, `PRESENT` or `FLUSH`.
- `in_ctr_start` while busy is dropped, not queued.
- Index arithmetic: unsigned `IDX_W` bits. Index never exceeds `TP_NUM`-1, so no wrap occurs.

## Timing
- Reset values: `out_ctr_Srst`=1, `out_ctr_en`=1; all other outputs 0; index 0; state `RST`.
- `in_ctr_start` at cycle t (enabled) gives `calInit` at t+1 and `out_valid` at t+2 with index 0.
- With `in_ready` held high, patterns k = 0..`TP_NUM`-1 are presented at cycles t+2+k. `out_done` is high at t+2+`TP_NUM`, and the state is `IDLE` in that same cycle.
- A new start is accepted in the `out_done` cycle.
- `in_ctr_en`=0 freezes state, index and `out_done` (the done pulse stretches). `out_valid` drops to 0.
- `in_ready` low holds the index and generator state indefinitely.
- Abort at cycle a: `out_ctr_Srst`=1 at a+1, `IDLE` at a+2.
- Async reset mid-operation: all outputs take their reset values immediately, with no pending done pulse.

## Structure
- Shared package `tsg_ctrl_pkg`: state encoding localparams (3-bit, binary), `TP_NUM_MAX`=8.
- One sub-module, `tp_idx_cnt`:
  - loadable up-counter with clear, increment enable and terminal flag `out_last`;
  - asynchronous active-low reset.
- The FSM and output decode stay in the top.

## Test plan
- Reset then idle, `TP_NUM`=4, ready=1, start at cycle 10 -> `calInit` at 11; valid with idx 0,1,2,3 at 12..15; `enCal` high at 12,13,14 only; `done` at 16.
- Ready toggling 1,0,0,1,… -> each index is held while ready=0; `enCal` is high only on transfer cycles; exactly 4 transfers, then `done`.
- Abort at the cycle of the idx-2 transfer -> no `enCal` or `done`; `Srst` for one cycle; `IDLE` two cycles later; start then behaves as in scenario 1.
- `in_ctr_en` low for 3 cycles during `PRESENT` and during the `done` pulse -> valid=0, `calInit`/`enCal`=0, index frozen, `done` stretched to 4 cycles.
- Start pulsed while busy, and start coincident with abort in `IDLE` -> both ignored, no `calInit`.
- Async reset asserted mid-`PRESENT` -> `Srst`=1, `en`=1, all other outputs 0 at once; `IDLE` on the first edge after release.
